// File: rtl/acc_cpu_sequencer_if.sv
// Byte-wide memory handshake between the sequencer (master) and the FPGA-side memory (slave).
interface acc_cpu_sequencer_if;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/acc_cpu_sequencer.sv
// Fetch/decode/execute controller for the 8-bit accumulator CPU: owns PC/AC/MDR/IR/operand,
// feeds the ALU, resolves branches/STORE/HALT and runs the memory handshake.
module acc_cpu_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter bit         AUTO_RUN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  acc_cpu_sequencer_if.master        mem,
  input  logic [7:0]                 alu_zout,
  input  logic                       alu_nflg,
  input  logic                       alu_zflg,
  output logic [7:0]                 opcode,
  output logic [7:0]                 value,
  output logic [7:0]                 addr,
  output logic [7:0]                 pc,
  output logic [7:0]                 ac,
  output logic [7:0]                 mdr,
  output logic                       instr_done,
  output logic                       halted
);

  localparam int unsigned W = 8;

  typedef enum logic [2:0] {
    IDLE, FETCH_OP, FETCH_ARG, READ, WRITE, EXEC, HALT
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   pc_q, pc_d, ac_q, ac_d, mdr_q, mdr_d;
  logic [W-1:0]   opcode_q, opcode_d, value_q, value_d;
  logic [W-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic           mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic           done_q, done_d, halted_q, halted_d;
  logic           taken;

  function automatic logic is_mem_op(input logic [W-1:0] op);
    return op inside {8'h01, 8'h05, 8'h07, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
  endfunction

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      ac_q        <= '0;
      mdr_q       <= '0;
      opcode_q    <= '0;
      value_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      done_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ac_q        <= ac_d;
      mdr_q       <= mdr_d;
      opcode_q    <= opcode_d;
      value_q     <= value_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      done_q      <= done_d;
      halted_q    <= halted_d;
    end
  end

  // Next-state, datapath updates and next-cycle memory request
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ac_d        = ac_q;
    mdr_d       = mdr_q;
    opcode_d    = opcode_q;
    value_d     = value_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    done_d      = 1'b0;
    halted_d    = 1'b0;
    taken       = 1'b0;

    case (state_q)
      IDLE: if (AUTO_RUN || run) state_d = FETCH_OP;
      FETCH_OP: if (mem.mem_ready) begin
        opcode_d = mem.mem_rdata;
        state_d  = FETCH_ARG;
      end
      FETCH_ARG: if (mem.mem_ready) begin
        value_d = mem.mem_rdata;
        if (is_mem_op(opcode_q))     state_d = READ;
        else if (opcode_q == 8'h03)  state_d = WRITE;
        else if (opcode_q == 8'h04)  state_d = HALT;
        else                         state_d = EXEC;
      end
      READ: if (mem.mem_ready) begin
        mdr_d   = mem.mem_rdata;
        state_d = EXEC;
      end
      WRITE: if (mem.mem_ready) begin
        pc_d    = pc_q + W'(2);
        done_d  = 1'b1;
        state_d = FETCH_OP;
      end
      EXEC: begin
        if (opcode_q inside {8'h01, 8'h02, [8'h05:8'h0F]}) ac_d = alu_zout;
        // Branch ops never write AC, so flags always reflect the settled AC
        case (opcode_q)
          8'h10:   taken = 1'b1;
          8'h11:   taken = alu_nflg;
          8'h12:   taken = !alu_nflg;
          8'h13:   taken = alu_zflg;
          8'h14:   taken = !alu_zflg;
          default: taken = 1'b0;
        endcase
        pc_d    = taken ? value_q : pc_q + W'(2);
        done_d  = 1'b1;
        state_d = FETCH_OP;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase

    // Requests are registered from the state being entered so they line up with it
    case (state_d)
      FETCH_OP: begin
        mem_rd_d   = 1'b1;
        mem_addr_d = pc_d;
      end
      FETCH_ARG: begin
        mem_rd_d   = 1'b1;
        mem_addr_d = pc_d + W'(1);
      end
      READ: begin
        mem_rd_d   = 1'b1;
        mem_addr_d = value_d;
      end
      WRITE: begin
        mem_wr_d    = 1'b1;
        mem_addr_d  = value_d;
        mem_wdata_d = ac_d;
      end
      HALT: halted_d = 1'b1;
      default: ;
    endcase
  end

  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_rd    = mem_rd_q;
  assign mem.mem_wr    = mem_wr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign opcode        = opcode_q;
  assign value         = value_q;
  assign addr          = value_q;
  assign pc            = pc_q;
  assign ac            = ac_q;
  assign mdr           = mdr_q;
  assign instr_done    = done_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// Directed bench for acc_cpu_sequencer: program table run on an auto-run instance, plus
// hand sequences for reset-during-access and a run-gated instance with RESET_PC=FE.
module tb_acc_cpu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run0 = 1'b0, run1 = 1'b0;
  always #5 clk = ~clk;

  acc_cpu_sequencer_if m0();
  acc_cpu_sequencer_if m1();

  logic [7:0] opcode0, value0, addr0, pc0, ac0, mdr0, zout0;
  logic [7:0] opcode1, value1, addr1, pc1, ac1, mdr1, zout1;
  logic       done0, halted0, done1, halted1;

  // Small ALU model: 01 load mem, 02 load imm, 05 add mem, 06 add imm, others xor imm
  function automatic logic [7:0] alu_f(input logic [7:0] op, a, v, m);
    case (op)
      8'h01:   return m;
      8'h02:   return v;
      8'h05:   return a + m;
      8'h06:   return a + v;
      default: return a ^ v;
    endcase
  endfunction

  assign zout0 = alu_f(opcode0, ac0, value0, mdr0);
  assign zout1 = alu_f(opcode1, ac1, value1, mdr1);

  acc_cpu_sequencer #(.RESET_PC(8'h00), .AUTO_RUN(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .run(run0), .mem(m0),
    .alu_zout(zout0), .alu_nflg(ac0[7]), .alu_zflg(ac0 == 8'h00),
    .opcode(opcode0), .value(value0), .addr(addr0), .pc(pc0), .ac(ac0), .mdr(mdr0),
    .instr_done(done0), .halted(halted0)
  );

  acc_cpu_sequencer #(.RESET_PC(8'hFE), .AUTO_RUN(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .run(run1), .mem(m1),
    .alu_zout(zout1), .alu_nflg(ac1[7]), .alu_zflg(ac1 == 8'h00),
    .opcode(opcode1), .value(value1), .addr(addr1), .pc(pc1), .ac(ac1), .mdr(mdr1),
    .instr_done(done1), .halted(halted1)
  );

  // Memory models: combinational read data, mem_ready after 'waits' stall cycles
  logic [7:0]  mem0 [256];
  logic [7:0]  mem1 [256];
  int unsigned waits0 = 0;
  int unsigned wc0 = 0, wc1 = 0;

  assign m0.mem_rdata = mem0[m0.mem_addr];
  assign m0.mem_ready = (m0.mem_rd | m0.mem_wr) && (wc0 >= waits0);
  assign m1.mem_rdata = mem1[m1.mem_addr];
  assign m1.mem_ready = (m1.mem_rd | m1.mem_wr);

  always @(posedge clk) begin
    if ((m0.mem_rd | m0.mem_wr) && !m0.mem_ready) wc0 <= wc0 + 1;
    else wc0 <= 0;
    wc1 <= 0;
  end

  typedef struct packed {
    logic [0:15][7:0] prog;
    logic [7:0]       xa;
    logic [7:0]       xd;
    logic [1:0]       waits;
    logic [7:0]       e_ac;
    logic [7:0]       e_pc;
    logic [7:0]       e_mdr;
    logic [3:0]       e_done;
  } vec_t;

  vec_t vt [12];

  int nvec = 0, errs = 0;
  int done_cnt0, wr_cyc0, cyc0, halt_at0, rd_cyc1;
  logic [7:0]   wr_addr0, wr_data0;
  logic [255:0] rd_hit0, rd_hit1;
  logic         p_ok0, p_rd0, p_wr0, p_rdy0;
  logic [7:0]   p_addr0, p_wd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle, sample on the falling edge and track handshake behaviour
  task automatic tick();
    @(negedge clk);
    if (!rst_n) begin
      done_cnt0 = 0; wr_cyc0 = 0; cyc0 = 0; halt_at0 = 0; rd_cyc1 = 0;
      wr_addr0 = '0; wr_data0 = '0; rd_hit0 = '0; rd_hit1 = '0;
      p_ok0 = 1'b0; p_rd0 = 1'b0; p_wr0 = 1'b0; p_rdy0 = 1'b0; p_addr0 = '0; p_wd0 = '0;
    end else begin
      cyc0++;
      if (halted0 && halt_at0 == 0) halt_at0 = cyc0;
      if (done0) done_cnt0++;
      if (m0.mem_wr) begin
        wr_cyc0++;
        wr_addr0 = m0.mem_addr;
        wr_data0 = m0.mem_wdata;
      end
      if (m0.mem_rd && m0.mem_ready) rd_hit0[m0.mem_addr] = 1'b1;
      if (m1.mem_rd && m1.mem_ready) rd_hit1[m1.mem_addr] = 1'b1;
      if (m1.mem_rd || m1.mem_wr) rd_cyc1++;
      chk("rd_wr_exclusive", 32'(m0.mem_rd & m0.mem_wr), 32'd0);
      if (p_ok0 && (p_rd0 || p_wr0) && !p_rdy0) begin
        chk("req_held", {m0.mem_rd, m0.mem_wr}, {p_rd0, p_wr0});
        chk("addr_held", m0.mem_addr, p_addr0);
        if (p_wr0) chk("wdata_held", m0.mem_wdata, p_wd0);
      end
      p_ok0 = 1'b1; p_rd0 = m0.mem_rd; p_wr0 = m0.mem_wr; p_rdy0 = m0.mem_ready;
      p_addr0 = m0.mem_addr; p_wd0 = m0.mem_wdata;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    for (int a = 0; a < 256; a++) mem0[a] = 8'h04;
    for (int a = 0; a < 16; a++) mem0[a] = v.prog[a];
    mem0[v.xa] = v.xd;
    waits0 = 32'(v.waits);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 300 && !halted0; c++) tick();
    chk($sformatf("v%0d_halted", idx), 32'(halted0), 32'd1);
    chk($sformatf("v%0d_ac", idx), ac0, v.e_ac);
    chk($sformatf("v%0d_pc", idx), pc0, v.e_pc);
    chk($sformatf("v%0d_mdr", idx), mdr0, v.e_mdr);
    chk($sformatf("v%0d_done", idx), done_cnt0, 32'(v.e_done));
  endtask

  initial begin
    bit found;
    for (int a = 0; a < 256; a++) mem1[a] = 8'h00;
    mem1[8'hFE] = 8'h02; mem1[8'hFF] = 8'h11; mem1[8'h00] = 8'h04;

    vt[0]  = '{prog: 128'h02050603_04000000_00000000_00000000, xa: 8'hF0, xd: 8'h04, waits: 2'd0,
               e_ac: 8'h08, e_pc: 8'h04, e_mdr: 8'h00, e_done: 4'd2};
    vt[1]  = '{prog: 128'h01800400_00000000_00000000_00000000, xa: 8'h80, xd: 8'h7F, waits: 2'd2,
               e_ac: 8'h7F, e_pc: 8'h02, e_mdr: 8'h7F, e_done: 4'd1};
    vt[2]  = '{prog: 128'h02001320_00000000_00000000_00000000, xa: 8'h20, xd: 8'h04, waits: 2'd0,
               e_ac: 8'h00, e_pc: 8'h20, e_mdr: 8'h00, e_done: 4'd2};
    vt[3]  = '{prog: 128'h02011320_04000000_00000000_00000000, xa: 8'h20, xd: 8'h04, waits: 2'd0,
               e_ac: 8'h01, e_pc: 8'h04, e_mdr: 8'h00, e_done: 4'd2};
    vt[4]  = '{prog: 128'h02F01140_00000000_00000000_00000000, xa: 8'h40, xd: 8'h04, waits: 2'd0,
               e_ac: 8'hF0, e_pc: 8'h40, e_mdr: 8'h00, e_done: 4'd2};
    vt[5]  = '{prog: 128'h02F01240_04000000_00000000_00000000, xa: 8'h40, xd: 8'h04, waits: 2'd0,
               e_ac: 8'hF0, e_pc: 8'h04, e_mdr: 8'h00, e_done: 4'd2};
    vt[6]  = '{prog: 128'h025A0390_04000000_00000000_00000000, xa: 8'hF0, xd: 8'h04, waits: 2'd0,
               e_ac: 8'h5A, e_pc: 8'h04, e_mdr: 8'h00, e_done: 4'd2};
    vt[7]  = '{prog: 128'h02031406_0000100A_00000400_00000000, xa: 8'hF0, xd: 8'h04, waits: 2'd1,
               e_ac: 8'h03, e_pc: 8'h0A, e_mdr: 8'h00, e_done: 4'd3};
    vt[8]  = '{prog: 128'h0000FF77_04000000_00000000_00000000, xa: 8'hF0, xd: 8'h04, waits: 2'd1,
               e_ac: 8'h00, e_pc: 8'h04, e_mdr: 8'h00, e_done: 4'd2};
    vt[9]  = '{prog: 128'h02100530_04000000_00000000_00000000, xa: 8'h30, xd: 8'h25, waits: 2'd1,
               e_ac: 8'h35, e_pc: 8'h04, e_mdr: 8'h25, e_done: 4'd2};
    vt[10] = '{prog: 128'h02001420_04000000_00000000_00000000, xa: 8'h20, xd: 8'h04, waits: 2'd0,
               e_ac: 8'h00, e_pc: 8'h04, e_mdr: 8'h00, e_done: 4'd2};
    vt[11] = '{prog: 128'h02101240_00000000_00000000_00000000, xa: 8'h40, xd: 8'h04, waits: 2'd3,
               e_ac: 8'h10, e_pc: 8'h40, e_mdr: 8'h00, e_done: 4'd2};

    // Reset values
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_pc0", pc0, 8'h00);
    chk("rst_pc1", pc1, 8'hFE);
    chk("rst_ac", ac0, 8'h00);
    chk("rst_mdr", mdr0, 8'h00);
    chk("rst_opcode", opcode0, 8'h00);
    chk("rst_value", value0, 8'h00);
    chk("rst_req", {m0.mem_rd, m0.mem_wr, done0, halted0}, 4'b0000);
    chk("rst_addr", m0.mem_addr, 8'h00);
    chk("rst_wdata", m0.mem_wdata, 8'h00);

    for (int i = 0; i < 12; i++) begin
      run_vec(vt[i], i);
      if (i == 0) chk("halt_latency", 32'(halt_at0 >= 8 && halt_at0 <= 9), 32'd1);
      if (i == 1) chk("read_at_80", 32'(rd_hit0[8'h80]), 32'd1);
      if (i == 6) begin
        chk("store_wr_cycles", wr_cyc0, 32'd1);
        chk("store_addr", wr_addr0, 8'h90);
        chk("store_wdata", wr_data0, 8'h5A);
      end
    end

    // Reset pulled during a stalled operand fetch
    for (int a = 0; a < 256; a++) mem0[a] = 8'h04;
    mem0[0] = 8'h02; mem0[1] = 8'h05;
    waits0 = 3;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (m0.mem_rd && m0.mem_addr == 8'h01 && !m0.mem_ready) begin
        found = 1'b1;
        break;
      end
    end
    chk("fetch_arg_wait_seen", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_rd", 32'(m0.mem_rd), 32'd0);
    chk("midreset_pc", pc0, 8'h00);
    chk("midreset_opcode", opcode0, 8'h00);
    chk("midreset_ac", ac0, 8'h00);
    tick(); tick();

    // Run-gated instance: no fetch until run, then wrap from FE/FF to 00
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    chk("norun_no_fetch", rd_cyc1, 32'd0);
    chk("norun_pc", pc1, 8'hFE);
    run1 = 1'b1;
    tick();
    run1 = 1'b0;
    for (int c = 0; c < 50 && !halted1; c++) tick();
    chk("wrap_halted", 32'(halted1), 32'd1);
    chk("wrap_ac", ac1, 8'h11);
    chk("wrap_pc", pc1, 8'h00);
    chk("wrap_operand_ff", 32'(rd_hit1[8'hFF]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
